// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and segment patterns for the display scan receiver.
// Patterns are active-low {g,f,e,d,c,b,a}; dp is handled separately.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index of the (single) set bit of a digit-select mask.
    function automatic logic [2:0] digit_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_to_hex.sv
// seg7_to_hex: combinational 7-segment pattern to hex nibble decoder.
// A fully dark digit decodes as a valid 0.
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    // Table lookup; anything not in the table is flagged invalid.
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: nibble = 4'h0;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receives the multiplexed SEG/AN scan and rebuilds the display word.
// Optional macro FRAME_CHANGE_EN adds the frame_changed output.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  seg,
    input  logic [7:0]  an,
    output logic [31:0] disp_word,
    output logic [7:0]  disp_dp,
    output logic        frame_valid,
    output logic        decode_err,
    output logic [2:0]  err_digit
`ifdef FRAME_CHANGE_EN
    ,
    output logic        frame_changed
`endif
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    latch_an;
    logic [7:0]    latch_seg;
    logic [7:0]    stab_cnt;
    logic [7:0]    an_act;
    logic          one_hot;
    logic          multi;
    logic          match;
    logic          settled;
    logic [2:0]    dig_idx;
    logic [3:0]    hex_nib;
    logic          hex_ok;
    logic [31:0]   shadow_word;
    logic [31:0]   word_upd;
    logic [7:0]    shadow_dp;
    logic [7:0]    dp_upd;
    logic [7:0]    seen;
    logic [7:0]    seen_upd;
    logic          cap;
    logic          cap_ok;
    logic          frame_done;
    logic          tmo_hit;
    logic [TW-1:0] tmo_cnt;

    assign an_act     = ~an;
    assign multi      = (an_act & (an_act - 8'd1)) != 8'd0;
    assign one_hot    = (an_act != 8'd0) && !multi;
    assign match      = (an == latch_an) && (seg == latch_seg);
    assign settled    = ({1'b0, stab_cnt} + 9'd1) >= 9'(STABLE_CYCLES);
    assign dig_idx    = digit_index(~latch_an);
    assign cap        = (state_q == CAPTURE);
    assign cap_ok     = cap && hex_ok;
    assign tmo_hit    = (tmo_cnt == TW'(FRAME_TIMEOUT));
    assign frame_done = (seen_upd == 8'hFF);

    seg7_to_hex u_dec (
        .seg    (latch_seg[6:0]),
        .nibble (hex_nib),
        .valid  (hex_ok)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic for the scan tracker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (one_hot) state_d = SETTLE;
            SETTLE: begin
                if (!match)       state_d = IDLE;
                else if (settled) state_d = CAPTURE;
            end
            CAPTURE: state_d = HOLD;
            HOLD:    if (an != latch_an) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the digit being settled and count how long it has held.
    always_ff @(posedge clk) begin
        if (clr) begin
            latch_an  <= 8'hFF;
            latch_seg <= 8'hFF;
            stab_cnt  <= 8'd0;
        end else if (state_q == IDLE && one_hot) begin
            latch_an  <= an;
            latch_seg <= seg;
            stab_cnt  <= 8'd1;
        end else if (state_q == SETTLE && match) begin
            stab_cnt  <= stab_cnt + 8'd1;
        end
    end

    // Shadow contents after merging this cycle's capture.
    always_comb begin
        word_upd = shadow_word;
        dp_upd   = shadow_dp;
        seen_upd = seen;
        if (cap_ok) begin
            word_upd[{dig_idx, 2'b00} +: 4] = hex_nib;
            dp_upd[dig_idx]                 = ~latch_seg[7];
            seen_upd[dig_idx]               = 1'b1;
        end
    end

    // Shadow slots, frame publication and sticky error reporting.
    always_ff @(posedge clk) begin
        if (clr) begin
            shadow_word <= 32'd0;
            shadow_dp   <= 8'd0;
            seen        <= 8'd0;
            disp_word   <= 32'd0;
            disp_dp     <= 8'd0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            err_digit   <= 3'd0;
        end else begin
            frame_valid <= 1'b0;
            shadow_word <= word_upd;
            shadow_dp   <= dp_upd;
            if (frame_done) begin
                disp_word   <= word_upd;
                disp_dp     <= dp_upd;
                frame_valid <= 1'b1;
                seen        <= 8'd0;
            end else if (!cap && tmo_hit) begin
                seen <= 8'd0;
            end else begin
                seen <= seen_upd;
            end
            if (cap && !hex_ok) begin
                decode_err <= 1'b1;
                err_digit  <= dig_idx;
            end
            if (state_q == IDLE && multi) decode_err <= 1'b1;
        end
    end

    // Saturating idle counter; any capture restarts it.
    always_ff @(posedge clk) begin
        if (clr)          tmo_cnt <= '0;
        else if (cap)     tmo_cnt <= '0;
        else if (!tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
    end

`ifdef FRAME_CHANGE_EN
    logic prev_ok;

    // Flag frames whose published value differs from the one on display.
    always_ff @(posedge clk) begin
        if (clr) begin
            frame_changed <= 1'b0;
            prev_ok       <= 1'b0;
        end else begin
            frame_changed <= 1'b0;
            if (frame_done) begin
                frame_changed <= !prev_ok ||
                                 ({dp_upd, word_upd} != {disp_dp, disp_word});
                prev_ok       <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: scenario tasks plus a frame-level reference model
// of the display scan receiver.
module tb_seg_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 1000;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic [31:0] disp_word;
    logic [7:0]  disp_dp;
    logic        frame_valid;
    logic        decode_err;
    logic [2:0]  err_digit;
    logic        chg_sig;
`ifdef FRAME_CHANGE_EN
    logic        frame_changed;
    assign chg_sig = frame_changed;
`else
    assign chg_sig = 1'b0;
`endif

    always #5 clk = ~clk;

    seg_scan_capture #(
        .STABLE_CYCLES (STABLE),
        .FRAME_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .seg         (seg),
        .an          (an),
        .disp_word   (disp_word),
        .disp_dp     (disp_dp),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .err_digit   (err_digit)
`ifdef FRAME_CHANGE_EN
        ,
        .frame_changed (frame_changed)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                             8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                             8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state: frame-level view of the display.
    logic [31:0] m_word;
    logic [7:0]  m_dp;
    logic [7:0]  m_seen;
    logic        m_err;
    logic [2:0]  m_errd;
    logic [39:0] m_last;
    bit          m_have;
    logic [40:0] exp_q [$];
    logic [40:0] got_q [$];

    always @(negedge clk) begin
        if (frame_valid) got_q.push_back({chg_sig, disp_dp, disp_word});
    end

    function automatic bit model_decode(input logic [6:0] s, output logic [3:0] n);
        n = 4'h0;
        if (s == 7'h7F) return 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pat[i][6:0] == s) begin
                n = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_word = 0; m_dp = 0; m_seen = 0;
        m_err = 0; m_errd = 0; m_last = 0; m_have = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic model_capture(input int d, input logic [7:0] s);
        logic [3:0] n;
        logic       chg;
        if (model_decode(s[6:0], n)) begin
            m_word[d*4 +: 4] = n;
            m_dp[d]          = ~s[7];
            m_seen[d]        = 1'b1;
            if (m_seen == 8'hFF) begin
                chg = !m_have || ({m_dp, m_word} != m_last);
`ifndef FRAME_CHANGE_EN
                chg = 1'b0;
`endif
                exp_q.push_back({chg, m_dp, m_word});
                m_last = {m_dp, m_word};
                m_have = 1'b1;
                m_seen = 8'd0;
            end
        end else begin
            m_err  = 1'b1;
            m_errd = 3'(d);
        end
    endtask

    task automatic idle(input int n);
        an = 8'hFF; seg = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one digit for 'hold' cycles followed by a short dark gap.
    task automatic scan_digit(input int d, input logic [7:0] s, input int hold);
        an  = ~(8'(1) << d);
        seg = s;
        repeat (hold) @(posedge clk);
        #1;
        if (hold >= STABLE) model_capture(d, s);
        idle(2);
    endtask

    task automatic do_reset();
        clr = 1'b1; an = 8'hFF; seg = 8'hFF;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        clr = 1'b1; an = 8'h00; seg = 8'h12;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0; an = 8'hFF; seg = 8'hFF;
        model_clear();
        n_vec++;
        if (disp_word !== 32'd0) begin
            n_err++; $display("FAIL reset_word got %h want 0", disp_word);
        end
        n_vec++;
        if (disp_dp !== 8'd0) begin
            n_err++; $display("FAIL reset_dp got %h want 0", disp_dp);
        end
        n_vec++;
        if (frame_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b want 0", frame_valid);
        end
        n_vec++;
        if (decode_err !== 1'b0) begin
            n_err++; $display("FAIL reset_err got %b want 0", decode_err);
        end
        n_vec++;
        if (err_digit !== 3'd0) begin
            n_err++; $display("FAIL reset_errdig got %0d want 0", err_digit);
        end
    endtask

    task automatic test_basic_scan();
        do_reset();
        for (int d = 0; d < 8; d++) scan_digit(d, pat[d+1], 10);
        idle(4);
        n_vec++;
        if (got_q.size() !== 1) begin
            n_err++; $display("FAIL basic_count got %0d want 1", got_q.size());
        end
        n_vec++;
        if (disp_word !== 32'h87654321) begin
            n_err++; $display("FAIL basic_word got %h want 87654321", disp_word);
        end
        n_vec++;
        if (disp_dp !== 8'h00) begin
            n_err++; $display("FAIL basic_dp got %h want 00", disp_dp);
        end
        n_vec++;
        if (decode_err !== 1'b0) begin
            n_err++; $display("FAIL basic_err got %b want 0", decode_err);
        end
    endtask

    task automatic test_short_hold();
        do_reset();
        for (int d = 0; d < 8; d++) scan_digit(d, pat[d+1], STABLE - 1);
        idle(4);
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL short_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        n_vec++;
        if (disp_word !== 32'd0) begin
            n_err++; $display("FAIL short_word got %h want 0", disp_word);
        end
    endtask

    task automatic test_multi_anode();
        do_reset();
        an = 8'hFC; seg = 8'hC0;
        repeat (6) @(posedge clk);
        #1;
        m_err = 1'b1;
        idle(2);
        n_vec++;
        if (decode_err !== m_err) begin
            n_err++; $display("FAIL multi_err got %b want %b", decode_err, m_err);
        end
        for (int d = 0; d < 8; d++) scan_digit(d, 8'hC0, 10);
        idle(4);
        n_vec++;
        if (got_q.size() !== 1) begin
            n_err++; $display("FAIL multi_count got %0d want 1", got_q.size());
        end
        n_vec++;
        if (disp_word !== 32'd0) begin
            n_err++; $display("FAIL multi_word got %h want 0", disp_word);
        end
        n_vec++;
        if (decode_err !== 1'b1) begin
            n_err++; $display("FAIL multi_sticky got %b want 1", decode_err);
        end
    endtask

    task automatic test_invalid_digit();
        do_reset();
        for (int d = 0; d < 8; d++)
            scan_digit(d, (d == 3) ? 8'hFE : pat[d], 10);
        idle(4);
        n_vec++;
        if (decode_err !== 1'b1) begin
            n_err++; $display("FAIL inv_err got %b want 1", decode_err);
        end
        n_vec++;
        if (err_digit !== m_errd) begin
            n_err++; $display("FAIL inv_errdig got %0d want %0d", err_digit, m_errd);
        end
        n_vec++;
        if (got_q.size() !== 0) begin
            n_err++; $display("FAIL inv_early got %0d frames want 0", got_q.size());
        end
        scan_digit(3, pat[3], 10);
        idle(4);
        n_vec++;
        if (got_q.size() !== 1) begin
            n_err++; $display("FAIL inv_count got %0d want 1", got_q.size());
        end
        n_vec++;
        if (disp_word !== 32'h76543210) begin
            n_err++; $display("FAIL inv_word got %h want 76543210", disp_word);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int d = 0; d < 5; d++) scan_digit(d, pat[5], 10);
        idle(TMO + 20);
        m_seen = 8'd0;
        for (int k = 0; k < 8; k++) begin
            int d;
            d = (k + 5) % 8;
            scan_digit(d, (d == 0) ? 8'h08 : 8'h88, 10);
            if (k == 2) begin
                n_vec++;
                if (got_q.size() !== 0) begin
                    n_err++; $display("FAIL tmo_stale got %0d frames want 0", got_q.size());
                end
            end
        end
        idle(4);
        n_vec++;
        if (got_q.size() !== 1) begin
            n_err++; $display("FAIL tmo_count got %0d want 1", got_q.size());
        end
        n_vec++;
        if (disp_word !== 32'hAAAAAAAA) begin
            n_err++; $display("FAIL tmo_word got %h want AAAAAAAA", disp_word);
        end
        n_vec++;
        if (disp_dp !== 8'h01) begin
            n_err++; $display("FAIL tmo_dp got %h want 01", disp_dp);
        end
    endtask

    task automatic test_clr_midframe();
        do_reset();
        for (int d = 0; d < 8; d++) scan_digit(d, pat[$urandom_range(1, 15)] & 8'h7F, 10);
        for (int d = 0; d < 3; d++) scan_digit(d, pat[9], 10);
        an = 8'h00; seg = 8'hC0;
        repeat (3) @(posedge clk);
        #1;
        idle(2);
        n_vec++;
        if (got_q.size() !== 1 || disp_word !== exp_q[0][31:0]) begin
            n_err++; $display("FAIL clr_pre got %h want %h", disp_word, exp_q[0][31:0]);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        n_vec++;
        if ({disp_word, disp_dp, frame_valid, decode_err, err_digit} !== 45'd0) begin
            n_err++;
            $display("FAIL clr_outputs got %h/%h/%b/%b/%0d want all 0",
                     disp_word, disp_dp, frame_valid, decode_err, err_digit);
        end
        for (int d = 3; d < 8; d++) scan_digit(d, pat[2], 10);
        idle(4);
        n_vec++;
        if (got_q.size() !== 0) begin
            n_err++; $display("FAIL clr_partial got %0d frames want 0", got_q.size());
        end
    endtask

    task automatic test_frame_change();
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int d = 0; d < 8; d++)
                scan_digit(d, (f == 2 && d == 6) ? pat[12] : pat[7 - d], 10);
        idle(4);
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL chg_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL chg_frame%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
`ifdef FRAME_CHANGE_EN
        if (got_q.size() == 3) begin
            n_vec++;
            if ({got_q[0][40], got_q[1][40], got_q[2][40]} !== 3'b101) begin
                n_err++;
                $display("FAIL chg_flags got %b%b%b want 101",
                         got_q[0][40], got_q[1][40], got_q[2][40]);
            end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 120; k++) begin
            int         d;
            int         r;
            logic [7:0] s;
            d = $urandom_range(0, 7);
            r = $urandom_range(0, 19);
            if (r < 16)       s = pat[r];
            else if (r == 16) s = 8'hFF;
            else              s = 8'($urandom_range(0, 255)) | 8'h80;
            s[7] = 1'($urandom_range(0, 1));
            scan_digit(d, s, $urandom_range(1, 8));
        end
        idle(4);
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rnd_frame%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_vec++;
        if (decode_err !== m_err) begin
            n_err++; $display("FAIL rnd_err got %b want %b", decode_err, m_err);
        end
        n_vec++;
        if (err_digit !== m_errd) begin
            n_err++; $display("FAIL rnd_errdig got %0d want %0d", err_digit, m_errd);
        end
        n_vec++;
        if ({disp_dp, disp_word} !== m_last) begin
            n_err++; $display("FAIL rnd_disp got %h want %h", {disp_dp, disp_word}, m_last);
        end
    endtask

    initial begin
        clr = 1'b1; an = 8'hFF; seg = 8'hFF;
        test_reset();
        test_basic_scan();
        test_short_hold();
        test_multi_anode();
        test_invalid_digit();
        test_timeout();
        test_clr_midframe();
        test_frame_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
